// File: rtl/lookup_table_programmer.sv
// lookup_table_programmer: decodes a 32-bit cfg word stream for one lookup
// stage and programs its match table (key/mask) and action RAM.
// Ports: clk, rst (sync, active-high); cfg_data/cfg_valid/cfg_ready command
// stream; lookup_din/_mask/_addr/_en match-table write; action_data_in/
// action_addr/action_en action write; cmd_done pulse; err_cnt saturating;
// cam_wr_cnt/act_wr_cnt write counters (live only with LKP_PROG_STATS_EN).
module lookup_table_programmer #(
  parameter int STAGE      = 0,
  parameter int KEY_LEN    = 197,
  parameter int ACT_LEN    = 25,
  parameter int CAM_ADDR_W = 4,
  parameter int ACT_ADDR_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             cfg_data,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  output logic [KEY_LEN-1:0]      lookup_din,
  output logic [KEY_LEN-1:0]      lookup_din_mask,
  output logic [CAM_ADDR_W-1:0]   lookup_din_addr,
  output logic                    lookup_din_en,
  output logic [ACT_LEN*25-1:0]   action_data_in,
  output logic [ACT_ADDR_W-1:0]   action_addr,
  output logic                    action_en,
  output logic                    cmd_done,
  output logic [7:0]              err_cnt,
  output logic [15:0]             cam_wr_cnt,
  output logic [15:0]             act_wr_cnt
);

  localparam int ACT_W = ACT_LEN * 25;
  localparam int KW    = (KEY_LEN + 31) / 32;
  localparam int AW    = (ACT_W + 31) / 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,
    S_MASK,
    S_ACT,
    S_COMMIT,
    S_DROP
  } state_t;

  state_t state_q, state_d;

  logic [KEY_LEN-1:0] key_q;
  logic [KEY_LEN-1:0] mask_q;
  logic [ACT_W-1:0]   act_q;
  logic [7:0]         addr_q;
  logic               is_cam_q;
  logic               done_q;
  logic [15:0]        cnt_q;
  logic [15:0]        last_q;

  logic       xfer;
  logic [3:0] hdr_op;
  logic [3:0] hdr_stg;
  logic [7:0] hdr_addr;
  logic       hdr_wr;
  logic       hdr_cam;
  logic       hdr_own;
  logic       cam_ok;
  logic       act_ok;
  logic       addr_ok;
  logic       wlast;
  logic       unused_bits;

  assign xfer     = cfg_valid && cfg_ready;
  assign hdr_op   = cfg_data[31:28];
  assign hdr_stg  = cfg_data[27:24];
  assign hdr_addr = cfg_data[23:16];
  assign hdr_cam  = (hdr_op == 4'd1);
  assign hdr_wr   = hdr_cam || (hdr_op == 4'd2);
  assign hdr_own  = (hdr_stg == 4'(STAGE));
  assign cam_ok   = (32'(hdr_addr) >> CAM_ADDR_W) == 32'd0;
  assign act_ok   = (32'(hdr_addr) >> ACT_ADDR_W) == 32'd0;
  assign addr_ok  = hdr_cam ? cam_ok : act_ok;
  assign wlast    = (cnt_q == last_q);

  assign unused_bits = ^{cfg_data[15:0], addr_q};

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    cfg_ready     = !rst && (state_q != S_COMMIT);
    lookup_din_en = 1'b0;
    action_en     = 1'b0;
    cmd_done      = done_q;
    unique case (state_q)
      S_IDLE: begin
        if (xfer && hdr_wr) begin
          if (hdr_own && addr_ok)
            state_d = hdr_cam ? S_KEY : S_ACT;
          else
            state_d = S_DROP;
        end
      end
      S_KEY: begin
        if (xfer && wlast) state_d = S_MASK;
      end
      S_MASK, S_ACT: begin
        if (xfer && wlast) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        lookup_din_en = is_cam_q;
        action_en     = !is_cam_q;
        cmd_done      = 1'b1;
        state_d       = S_IDLE;
      end
      S_DROP: begin
        if (xfer && wlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Payload words arrive MSB-first; shifting left keeps the low field bits
  // and lets the excess high bits of the first word fall off the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q           <= '0;
      mask_q          <= '0;
      act_q           <= '0;
      addr_q          <= '0;
      is_cam_q        <= 1'b0;
      done_q          <= 1'b0;
      cnt_q           <= '0;
      last_q          <= '0;
      err_cnt         <= '0;
      lookup_din      <= '0;
      lookup_din_mask <= '0;
      lookup_din_addr <= '0;
      action_data_in  <= '0;
      action_addr     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (xfer) begin
            is_cam_q <= hdr_cam;
            addr_q   <= hdr_addr;
            cnt_q    <= '0;
            if (!hdr_cam)
              last_q <= 16'(AW - 1);
            else if (hdr_own && addr_ok)
              last_q <= 16'(KW - 1);
            else
              last_q <= 16'(2 * KW - 1);
            if (!hdr_wr) begin
              done_q <= 1'b1;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end else if (hdr_own && !addr_ok) begin
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
          end
        end
        S_KEY: begin
          if (xfer) begin
            key_q <= {key_q[KEY_LEN-33:0], cfg_data};
            cnt_q <= wlast ? '0 : cnt_q + 16'd1;
          end
        end
        S_MASK: begin
          if (xfer) begin
            mask_q <= {mask_q[KEY_LEN-33:0], cfg_data};
            cnt_q  <= cnt_q + 16'd1;
            if (wlast) begin
              lookup_din      <= key_q;
              lookup_din_mask <= {mask_q[KEY_LEN-33:0], cfg_data};
              lookup_din_addr <= addr_q[CAM_ADDR_W-1:0];
            end
          end
        end
        S_ACT: begin
          if (xfer) begin
            act_q <= {act_q[ACT_W-33:0], cfg_data};
            cnt_q <= cnt_q + 16'd1;
            if (wlast) begin
              action_data_in <= {act_q[ACT_W-33:0], cfg_data};
              action_addr    <= addr_q[ACT_ADDR_W-1:0];
            end
          end
        end
        S_DROP: begin
          if (xfer) begin
            cnt_q <= cnt_q + 16'd1;
            if (wlast) done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LKP_PROG_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cam_wr_cnt <= '0;
      act_wr_cnt <= '0;
    end else begin
      if (lookup_din_en) cam_wr_cnt <= cam_wr_cnt + 16'd1;
      if (action_en)     act_wr_cnt <= act_wr_cnt + 16'd1;
    end
  end
`else
  assign cam_wr_cnt = '0;
  assign act_wr_cnt = '0;
`endif

endmodule
